parity_scheduler: RTL and testbench

PARITY_SCHEDULER -- requirements
Module: parity_scheduler

---
 rtl/parity_sched_pkg.sv | 16 +
 rtl/parity_serial_engine.sv | 53 +++++
 rtl/parity_scheduler.sv | 120 ++++++++++++
 tb/tb_parity_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
// Purpose: shared FSM state encoding and default sizing for the parity scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (IDLE/CALC/DONE), NUM_REQ_DEF, DATA_WIDTH_DEF.
package parity_sched_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/parity_serial_engine.sv
// Purpose: bit-serial parity engine; one word bit folded into acc per cycle.
// Latency: DATA_WIDTH cycles after load; last/parity look ahead to the final shift.
// Backpressure: none; load restarts the engine unconditionally.
// Ports: clk, reset (sync, active-high), load/word (capture strobe and word),
//        last (final shift happens at the coming edge), parity (acc after that shift).
module parity_serial_engine
  import parity_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  last,
  output logic                  parity
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  acc;
  logic [CNT_W-1:0]      cnt;
  // active keeps the counter from running outside a calculation.
  logic                  active;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
      active    <= 1'b0;
    end else if (load) begin
      shift_reg <= word;
      acc       <= 1'b0;
      cnt       <= '0;
      active    <= 1'b1;
    end else if (active) begin
      acc       <= acc ^ shift_reg[0];
      shift_reg <= shift_reg >> 1;
      cnt       <= cnt + CNT_W'(1);
      if (cnt == CNT_LAST) begin
        active <= 1'b0;
      end
    end
  end

  // Look-ahead lets the top register done in the same edge as the final shift.
  assign last   = active && (cnt == CNT_LAST);
  assign parity = acc ^ shift_reg[0];

endmodule

// File: rtl/parity_scheduler.sv
// Purpose: round-robin arbiter feeding a serial parity engine; one word at a time.
// Latency: req at edge k -> gnt in cycle k+1 -> done in cycle k+DATA_WIDTH+1.
// Backpressure: none; requesters hold req until gnt, req ignored while busy.
// Ports: clk, reset (sync, active-high), req/data_in (per-requester level and word),
//        gnt (one-hot pulse), busy, done (pulse), done_id, parity_out (valid with done).
module parity_scheduler
  import parity_sched_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                 data_in,
  output logic [NUM_REQ-1:0]                            gnt,
  output logic                                          busy,
  output logic                                          done,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] done_id,
  output logic                                          parity_out
);

  localparam int              ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W:0]   NREQ_W  = (ID_W + 1)'(NUM_REQ);
  localparam logic            ODD_BIT = (ODD_PARITY != 0);

  state_t                state;
  logic [ID_W-1:0]       last_winner;
  logic                  pick_vld;
  logic [ID_W-1:0]       pick_idx;
  logic [ID_W:0]         cand;
  logic [DATA_WIDTH-1:0] pick_word;
  logic                  load;
  logic                  eng_last;
  logic                  eng_parity;

  // Round-robin search starting one past the previous winner, modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_winner} + (ID_W + 1)'(off);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!pick_vld && req[cand[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        pick_word = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign load = (state == IDLE) && pick_vld;

  parity_serial_engine #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_engine (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .word   (pick_word),
    .last   (eng_last),
    .parity (eng_parity)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      parity_out  <= 1'b0;
      last_winner <= ID_W'(NUM_REQ - 1);
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state       <= CALC;
            gnt         <= NUM_REQ'(1) << pick_idx;
            busy        <= 1'b1;
            last_winner <= pick_idx;
          end
        end
        CALC: begin
          if (eng_last) begin
            state      <= DONE;
            done       <= 1'b1;
            done_id    <= last_winner;
            parity_out <= eng_parity ^ ODD_BIT;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done_id    <= '0;
          parity_out <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_scheduler.sv
// Purpose: self-checking bench for parity_scheduler (even and odd parity instances).
// Latency: reference timeline predicts gnt/busy/done per cycle from capture edges.
// Backpressure: bench requesters drop req in the cycle their gnt is expected.
module tb_parity_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] data_in;
  logic [NR-1:0]   gnt_e, gnt_o;
  logic            busy_e, busy_o, done_e, done_o, par_e, par_o;
  logic [1:0]      id_e, id_o;

  always #5 clk = ~clk;

  parity_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ODD_PARITY(0)) dut_even (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt_e),
    .busy(busy_e), .done(done_e), .done_id(id_e), .parity_out(par_e));

  parity_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt_o),
    .busy(busy_o), .done(done_o), .done_id(id_o), .parity_out(par_o));

  int checks = 0;
  int errors = 0;

  // Reference timeline: one job at a time, described by its grant cycle.
  int  cyc    = 0;
  bit  job    = 1'b0;
  int  jstart = 0;
  int  jid    = 0;
  bit  jpar   = 1'b0;
  int  lw     = NR - 1;

  logic [DW-1:0] words [NR];
  logic [NR-1:0] pend;

  int gnt_ids[$];
  int gnt_cyc[$];
  int done_ids[$];
  int done_par[$];
  int done_par_odd[$];
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(tag, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    gnt_ids.delete(); gnt_cyc.delete(); done_ids.delete();
    done_par.delete(); done_par_odd.delete();
  endtask

  // Drive one edge, advance the reference timeline, check the following cycle.
  task automatic step(input logic r);
    logic [NR-1:0] eg;
    bit win, dn;
    reset = r;
    req   = pend;
    for (int i = 0; i < NR; i++) data_in[i*DW +: DW] = words[i];
    if (r) begin
      job = 1'b0;
      lw  = NR - 1;
    end else if ((!job || cyc >= jstart + DW + 1) && pend != '0) begin
      for (int off = 1; off <= NR; off++) begin
        int w;
        w = (lw + off) % NR;
        if (pend[w]) begin
          job    = 1'b1;
          jstart = cyc + 1;
          jid    = w;
          jpar   = ($countones(words[w]) % 2) == 1;
          lw     = w;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    win = job && cyc >= jstart && cyc <= jstart + DW;
    dn  = job && cyc == jstart + DW;
    eg  = '0;
    if (job && cyc == jstart) eg[jid] = 1'b1;
    chk("gnt",        32'(gnt_e),  32'(eg));
    chk("gnt_odd",    32'(gnt_o),  32'(eg));
    chk("busy",       32'(busy_e), 32'(win));
    chk("busy_odd",   32'(busy_o), 32'(win));
    chk("done",       32'(done_e), 32'(dn));
    chk("done_odd",   32'(done_o), 32'(dn));
    chk("done_id",    32'(id_e),   dn ? 32'(jid) : 32'd0);
    chk("done_id_odd",32'(id_o),   dn ? 32'(jid) : 32'd0);
    chk("parity",     32'(par_e),  dn ? 32'(jpar) : 32'd0);
    chk("parity_odd", 32'(par_o),  dn ? 32'(!jpar) : 32'd0);
    if (gnt_e != '0) begin
      gnt_ids.push_back(oh_idx(gnt_e));
      gnt_cyc.push_back(cyc);
    end
    if (done_e) begin
      done_ids.push_back(int'(id_e));
      done_par.push_back(int'(par_e));
      done_par_odd.push_back(int'(par_o));
    end
    pend &= ~eg;
  endtask

  initial begin
    int rq, g, diffs[$];
    bit seen, rereq;
    pend    = '0;
    req     = '0;
    data_in = '0;
    reset   = 1'b1;
    for (int i = 0; i < NR; i++) words[i] = '0;

    // Reset state.
    step(1'b1);
    step(1'b1);

    // Single request, word 0 = A5.
    clear_logs();
    words[0] = 8'hA5;
    pend     = 4'b0001;
    rq       = cyc;
    repeat (12) step(1'b0);
    exp_q = {0};   chk_list("single_gnt_id", gnt_ids, exp_q);
    exp_q = {0};   chk_list("single_done_id", done_ids, exp_q);
    exp_q = {0};   chk_list("single_parity", done_par, exp_q);
    if (gnt_cyc.size() == 1) chk("single_gnt_cycle", 32'(gnt_cyc[0] - rq), 32'd1);

    // Odd number of ones, requester 2.
    clear_logs();
    words[2] = 8'h07;
    pend     = 4'b0100;
    repeat (12) step(1'b0);
    exp_q = {2};   chk_list("odd_done_id", done_ids, exp_q);
    exp_q = {1};   chk_list("odd_parity_even", done_par, exp_q);
    exp_q = {0};   chk_list("odd_parity_odd", done_par_odd, exp_q);

    // Contention: all four requesting from reset.
    step(1'b1);
    clear_logs();
    words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07; words[3] = 8'hFF;
    pend = 4'b1111;
    repeat (45) step(1'b0);
    exp_q = {0, 1, 2, 3}; chk_list("contend_order", gnt_ids, exp_q);
    exp_q = {1, 0, 1, 0}; chk_list("contend_parity", done_par, exp_q);
    diffs.delete();
    for (int i = 1; i < gnt_cyc.size(); i++) diffs.push_back(gnt_cyc[i] - gnt_cyc[i-1]);
    exp_q = {10, 10, 10}; chk_list("contend_spacing", diffs, exp_q);

    // Fairness: 0 re-requests right after its done while 3 waits.
    step(1'b1);
    clear_logs();
    words[0] = 8'h3C; words[3] = 8'h81;
    pend  = 4'b1001;
    rereq = 1'b0;
    for (int i = 0; i < 35; i++) begin
      step(1'b0);
      if (done_e && id_e == 2'd0 && !rereq) begin
        pend[0] = 1'b1;
        rereq   = 1'b1;
      end
    end
    exp_q = {0, 3, 0}; chk_list("fair_order", gnt_ids, exp_q);

    // Reset four cycles after a grant aborts the word; reset also beats a request.
    step(1'b1);
    clear_logs();
    words[0] = 8'h5A; words[1] = 8'hE0;
    pend = 4'b0001;
    seen = 1'b0;
    g    = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step(1'b0);
      if (gnt_e != '0) begin seen = 1'b1; g = cyc; end
    end
    chk("abort_gnt_seen", 32'(seen), 32'd1);
    repeat (3) step(1'b0);
    chk("abort_cycles_after_gnt", 32'(cyc - g), 32'd3);
    pend = 4'b0010;
    step(1'b1);
    chk("abort_busy_low", 32'(busy_e), 32'd0);
    repeat (12) step(1'b0);
    exp_q = {0, 1}; chk_list("abort_gnt_ids", gnt_ids, exp_q);
    exp_q = {1};    chk_list("abort_done_ids", done_ids, exp_q);

    // Request pulses that never sit on a capture edge.
    clear_logs();
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      req = 4'b0100;
      #2;
      step(1'b0);
    end
    exp_q.delete(); chk_list("glitch_gnt", gnt_ids, exp_q);

    // Randomized traffic with withdrawals and occasional resets.
    for (int n = 0; n < 500; n++) begin
      logic r;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 5) == 0) begin
          words[i] = 8'($urandom);
          pend[i]  = 1'b1;
        end
      end
      if ($urandom_range(0, 39) == 0) pend[$urandom_range(0, NR-1)] = 1'b0;
      r = ($urandom_range(0, 79) == 0);
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
